// File: rtl/bank_arb_pkg.sv
// Shared types and constants for the bank link arbiter.
// Holds the FSM state encoding, field widths and a cost-slot helper.
package bank_arb_pkg;

    localparam int NUM_REQ_DEF = 4;
    localparam int COST_W      = 3;
    localparam int CNT_W       = 8;
    localparam int GID_W       = 2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    function automatic logic [COST_W-1:0] cost_slot(
        input logic [NUM_REQ_DEF*COST_W-1:0] costs,
        input logic [GID_W-1:0]              idx
    );
        return costs[idx*COST_W +: COST_W];
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational 4-way round-robin picker: the search starts at (i_last+1) mod 4
// and returns the first active requester found.
module rr_picker (
    input  logic [3:0] i_req,
    input  logic [1:0] i_last,
    output logic       o_valid,
    output logic [1:0] o_idx
);

    logic [1:0] w_cand;

    // Walk from the farthest offset to the nearest so the nearest hit overwrites.
    always_comb begin
        o_valid = 1'b0;
        o_idx   = 2'd0;
        w_cand  = 2'd0;
        for (int k = 4; k >= 1; k--) begin
            w_cand = i_last + 2'(k);
            if (i_req[w_cand]) begin
                o_valid = 1'b1;
                o_idx   = w_cand;
            end
        end
    end

endmodule

// File: rtl/bank_link_arbiter.sv
// Arbitrates four vending-machine requesters onto one bank link with timeout and abort.
// Define BANK_ARB_STATS_EN to build the saturating approved/failed counters.
module bank_link_arbiter
    import bank_arb_pkg::*;
#(
    parameter int NUM_REQ     = NUM_REQ_DEF,
    parameter int TIMEOUT_CYC = 5
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic [NUM_REQ-1:0]        i_req,
    input  logic [NUM_REQ*COST_W-1:0] i_req_cost,
    output logic [NUM_REQ-1:0]        o_done,
    output logic [NUM_REQ-1:0]        o_ok,
    output logic                      o_bank_req,
    output logic [COST_W-1:0]         o_bank_amt,
    input  logic                      i_bank_ack,
    input  logic                      i_bank_ok,
    output logic                      o_busy,
    output logic [GID_W-1:0]          o_grant_id,
    output logic [CNT_W-1:0]          o_approved_cnt,
    output logic [CNT_W-1:0]          o_failed_cnt
);

    localparam int TMR_W = $clog2(TIMEOUT_CYC) + 1;

    state_t              r_state;
    state_t              w_next;
    logic [GID_W-1:0]    r_grant;
    logic [GID_W-1:0]    r_last;
    logic [COST_W-1:0]   r_cost;
    logic [TMR_W-1:0]    r_timer;
    logic                r_result;
    logic [NUM_REQ-1:0]  r_done;
    logic [NUM_REQ-1:0]  r_ok;

    logic                w_pick_valid;
    logic [GID_W-1:0]    w_pick_idx;
    logic                w_held;
    logic                w_timeout;
    logic [NUM_REQ-1:0]  w_grant_oh;

    rr_picker u_picker (
        .i_req   (i_req),
        .i_last  (r_last),
        .o_valid (w_pick_valid),
        .o_idx   (w_pick_idx)
    );

    assign w_held    = i_req[r_grant];
    assign w_timeout = (r_timer == TMR_W'(TIMEOUT_CYC - 1));

    always_comb begin
        w_grant_oh          = '0;
        w_grant_oh[r_grant] = 1'b1;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    // A dropped request (card removed) aborts before any bank result is considered.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_pick_valid) w_next = S_ISSUE;
            S_ISSUE: begin
                if (!w_held)              w_next = S_IDLE;
                else if (r_cost == '0)    w_next = S_RESP;
                else                      w_next = S_WAIT;
            end
            S_WAIT: begin
                if (!w_held)                      w_next = S_IDLE;
                else if (i_bank_ack || w_timeout) w_next = S_RESP;
            end
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_grant  <= '0;
            r_last   <= GID_W'(NUM_REQ - 1);
            r_cost   <= '0;
            r_timer  <= '0;
            r_result <= 1'b0;
            r_done   <= '0;
            r_ok     <= '0;
        end else begin
            r_done <= '0;
            r_ok   <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_pick_valid) begin
                        r_grant <= w_pick_idx;
                        r_cost  <= cost_slot(i_req_cost, w_pick_idx);
                    end
                end
                S_ISSUE: begin
                    r_timer  <= '0;
                    r_result <= 1'b0;
                end
                S_WAIT: begin
                    r_timer <= r_timer + 1'b1;
                    if (i_bank_ack) r_result <= i_bank_ok;
                end
                S_RESP: begin
                    r_done <= w_grant_oh;
                    r_ok   <= r_result ? w_grant_oh : '0;
                    r_last <= r_grant;
                end
                default: ;
            endcase
        end
    end

    assign o_done     = r_done;
    assign o_ok       = r_ok;
    assign o_bank_req = ((r_state == S_ISSUE) && (r_cost != '0)) || (r_state == S_WAIT);
    assign o_bank_amt = o_bank_req ? r_cost : '0;
    assign o_busy     = (r_state != S_IDLE);
    assign o_grant_id = (r_state == S_IDLE) ? '0 : r_grant;

`ifdef BANK_ARB_STATS_EN
    logic [CNT_W-1:0] r_approved;
    logic [CNT_W-1:0] r_failed;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_approved <= '0;
            r_failed   <= '0;
        end else if (r_state == S_RESP) begin
            if (r_result) begin
                if (r_approved != '1) r_approved <= r_approved + 1'b1;
            end else begin
                if (r_failed != '1) r_failed <= r_failed + 1'b1;
            end
        end
    end

    assign o_approved_cnt = r_approved;
    assign o_failed_cnt   = r_failed;
`else
    assign o_approved_cnt = '0;
    assign o_failed_cnt   = '0;
`endif

endmodule

// File: tb/tb_bank_link_arbiter.sv
// Scoreboard bench for bank_link_arbiter: stimulus pushes expected DONE/OK pairs,
// a negedge monitor pops and compares whenever DONE is presented.
module tb_bank_link_arbiter;

    typedef struct {
        logic [3:0] done;
        logic [3:0] ok;
        int         cyc;
    } exp_t;

`ifdef BANK_ARB_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk;
    logic        rstN;
    logic [3:0]  req;
    logic [11:0] reqCost;
    logic [3:0]  done;
    logic [3:0]  ok;
    logic        bankReq;
    logic [2:0]  bankAmt;
    logic        bankAck;
    logic        bankOk;
    logic        busy;
    logic [1:0]  grantId;
    logic [7:0]  approvedCnt;
    logic [7:0]  failedCnt;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   startCyc;
    bit   bankReqSeen;
    exp_t sbq[$];
    exp_t monE;

    bank_link_arbiter #(.NUM_REQ(4), .TIMEOUT_CYC(5)) dut (
        .i_clk          (clk),
        .i_rst_n        (rstN),
        .i_req          (req),
        .i_req_cost     (reqCost),
        .o_done         (done),
        .o_ok           (ok),
        .o_bank_req     (bankReq),
        .o_bank_amt     (bankAmt),
        .i_bank_ack     (bankAck),
        .i_bank_ok      (bankOk),
        .o_busy         (busy),
        .o_grant_id     (grantId),
        .o_approved_cnt (approvedCnt),
        .o_failed_cnt   (failedCnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] r, input logic [11:0] c, input logic a, input logic o);
        req     = r;
        reqCost = c;
        bankAck = a;
        bankOk  = o;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyReset();
        rstN = 1'b0;
        applyStimulus(4'b0000, 12'h000, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstN = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic pushExp(input logic [3:0] d, input logic [3:0] o, input int c);
        exp_t e;
        e.done = d;
        e.ok   = o;
        e.cyc  = c;
        sbq.push_back(e);
    endtask

    // Returns just after the negedge on which the last expected DONE was popped.
    task automatic drain(input string name);
        int guard = 0;
        while (sbq.size() != 0 && guard < 60) begin
            @(negedge clk);
            #1;
            guard++;
        end
        if (sbq.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s_timeout actual=%0d pending required=0 pending", name, sbq.size());
            sbq.delete();
        end
    endtask

    always @(negedge clk) begin
        if (rstN && bankReq) bankReqSeen = 1'b1;
        if (done != 4'b0000) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_done actual=%b required=none", done);
            end else begin
                monE = sbq.pop_front();
                checkOutput("done", 32'(done), 32'(monE.done));
                checkOutput("ok", 32'(ok), 32'(monE.ok));
                if (monE.cyc >= 0) checkOutput("done_cycle", 32'(cyc), 32'(monE.cyc));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog actual=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rstN = 1'b0;
        applyStimulus(4'b0000, 12'h000, 1'b0, 1'b0);
        #12;
        checkOutput("rst_busy", 32'(busy), 0);
        checkOutput("rst_bank_req", 32'(bankReq), 0);
        checkOutput("rst_done", 32'(done), 0);
        checkOutput("rst_ok", 32'(ok), 0);
        checkOutput("rst_grant", 32'(grantId), 0);
        checkOutput("rst_failed", 32'(failedCnt), 0);
        applyReset();

        // Uncompetitive approved request, ack in first WAIT cycle.
        applyStimulus(4'b0001, 12'h005, 1'b0, 1'b0);
        startCyc = cyc;
        pushExp(4'b0001, 4'b0001, startCyc + 4);
        waitCycles(1);
        checkOutput("issue_bank_req", 32'(bankReq), 1);
        checkOutput("issue_bank_amt", 32'(bankAmt), 5);
        checkOutput("issue_busy", 32'(busy), 1);
        waitCycles(1);
        applyStimulus(4'b0001, 12'h005, 1'b1, 1'b1);
        waitCycles(1);
        applyStimulus(4'b0001, 12'h005, 1'b0, 1'b0);
        drain("latency");
        applyStimulus(4'b0000, 12'h005, 1'b0, 1'b0);
        waitCycles(2);

        // Round robin with all four requesting.
        applyReset();
        applyStimulus(4'b1111, 12'h492, 1'b1, 1'b1);
        pushExp(4'b0001, 4'b0001, -1);
        pushExp(4'b0010, 4'b0010, -1);
        pushExp(4'b0100, 4'b0100, -1);
        pushExp(4'b1000, 4'b1000, -1);
        pushExp(4'b0001, 4'b0001, -1);
        drain("round_robin");
        applyStimulus(4'b0000, 12'h492, 1'b0, 1'b0);
        waitCycles(3);
        checkOutput("rr_idle_busy", 32'(busy), 0);

        // Timeout with no ack, then ack arriving on the timeout cycle.
        applyReset();
        applyStimulus(4'b0001, 12'h003, 1'b0, 1'b0);
        startCyc = cyc;
        pushExp(4'b0001, 4'b0000, startCyc + 8);
        waitCycles(4);
        checkOutput("wait_busy", 32'(busy), 1);
        checkOutput("wait_grant", 32'(grantId), 0);
        drain("timeout");
        applyStimulus(4'b0000, 12'h003, 1'b0, 1'b0);
        checkOutput("timeout_failed_cnt", 32'(failedCnt), STATS ? 1 : 0);
        checkOutput("timeout_approved_cnt", 32'(approvedCnt), 0);
        waitCycles(2);
        applyStimulus(4'b0001, 12'h003, 1'b0, 1'b0);
        startCyc = cyc;
        pushExp(4'b0001, 4'b0001, startCyc + 8);
        waitCycles(6);
        applyStimulus(4'b0001, 12'h003, 1'b1, 1'b1);
        waitCycles(1);
        applyStimulus(4'b0001, 12'h003, 1'b0, 1'b0);
        drain("ack_at_timeout");
        applyStimulus(4'b0000, 12'h003, 1'b0, 1'b0);
        checkOutput("ack_timeout_approved_cnt", 32'(approvedCnt), STATS ? 1 : 0);
        waitCycles(2);

        // Zero cost skips the bank entirely.
        bankReqSeen = 1'b0;
        applyStimulus(4'b0100, 12'h000, 1'b0, 1'b0);
        startCyc = cyc;
        pushExp(4'b0100, 4'b0000, startCyc + 3);
        drain("zero_cost");
        applyStimulus(4'b0000, 12'h000, 1'b0, 1'b0);
        checkOutput("zero_cost_bank_req_seen", 32'(bankReqSeen), 0);
        checkOutput("zero_cost_failed_cnt", 32'(failedCnt), STATS ? 2 : 0);
        waitCycles(2);

        // Card removed during WAIT: abort, late ack ignored.
        applyStimulus(4'b0010, 12'h020, 1'b0, 1'b0);
        waitCycles(2);
        checkOutput("abort_pre_bank_req", 32'(bankReq), 1);
        checkOutput("abort_pre_bank_amt", 32'(bankAmt), 4);
        checkOutput("abort_pre_grant", 32'(grantId), 1);
        applyStimulus(4'b0000, 12'h020, 1'b0, 1'b0);
        waitCycles(1);
        checkOutput("abort_bank_req", 32'(bankReq), 0);
        checkOutput("abort_busy", 32'(busy), 0);
        applyStimulus(4'b0000, 12'h020, 1'b1, 1'b1);
        waitCycles(1);
        applyStimulus(4'b0000, 12'h020, 1'b0, 1'b0);
        waitCycles(4);
        checkOutput("abort_after_busy", 32'(busy), 0);
        checkOutput("abort_approved_cnt", 32'(approvedCnt), STATS ? 1 : 0);
        checkOutput("abort_failed_cnt", 32'(failedCnt), STATS ? 2 : 0);

        // Asynchronous reset mid-WAIT, then lowest active requester wins.
        applyStimulus(4'b0001, 12'h249, 1'b0, 1'b0);
        waitCycles(2);
        checkOutput("pre_reset_bank_req", 32'(bankReq), 1);
        #2;
        rstN = 1'b0;
        #1;
        checkOutput("async_rst_bank_req", 32'(bankReq), 0);
        checkOutput("async_rst_busy", 32'(busy), 0);
        checkOutput("async_rst_failed_cnt", 32'(failedCnt), 0);
        applyStimulus(4'b1010, 12'h249, 1'b1, 1'b1);
        pushExp(4'b0010, 4'b0010, -1);
        pushExp(4'b1000, 4'b1000, -1);
        @(negedge clk);
        rstN = 1'b1;
        drain("post_reset");
        applyStimulus(4'b0000, 12'h249, 1'b0, 1'b0);
        waitCycles(3);
        checkOutput("final_approved_cnt", 32'(approvedCnt), STATS ? 2 : 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bank_link_arbiter.md
BANK_LINK_ARBITER -- requirements
Module: bank_link_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of vending-machine requesters (fixed at 4 in this release).
REQ-002 Parameter TIMEOUT_CYC, default 5: CLK cycles allowed for BANK_ACK after BANK_REQ rises.
REQ-003 CLK  input  1  single system clock, rising-edge.
REQ-004 RESET_N  input  1  asynchronous active-low reset.
REQ-005 REQ  input  4  per-machine authorization request, level, held until DONE.
REQ-006 REQ_COST  input  12  4x3-bit item cost; slot i = bits [3i+2:3i], stable while REQ[i]=1.
REQ-007 DONE  output  4  one-cycle pulse to the granted machine at transaction end.
REQ-008 OK  output  4  approval flag, valid only with DONE (VALID_TRAN to that machine).
REQ-009 BANK_REQ  output  1  request to the shared bank link.
REQ-010 BANK_AMT  output  3  cost sent to the bank.
REQ-011 BANK_ACK  input  1  bank response strobe.
REQ-012 BANK_OK  input  1  bank approval, sampled with BANK_ACK.
REQ-013 BUSY  output  1  high in any state other than IDLE.
REQ-014 GRANT_ID  output  2  index of the current grantee; 0 in IDLE.
REQ-015 APPROVED_CNT, FAILED_CNT  output  8 each  transaction statistics (see Configuration).

Function
REQ-016 FSM states: IDLE, ISSUE, WAIT, RESP.
REQ-017 IDLE: if any REQ bit is set, pick the grantee round-robin starting at (last_grant+1) mod 4, latch its cost, and enter ISSUE on the next edge.
REQ-018 ISSUE, latched cost = 0: skip the bank and go to RESP with OK=0 (invalid selection).
REQ-019 ISSUE, latched cost != 0: assert BANK_REQ with BANK_AMT = latched cost, clear the timeout counter, and enter WAIT.
REQ-020 WAIT: BANK_REQ stays high; the counter increments each cycle.
REQ-021 WAIT: BANK_ACK=1 drives RESP with result = BANK_OK.
REQ-022 WAIT: reaching TIMEOUT_CYC without BANK_ACK drives RESP with result = 0 (FAILED_TRAN).
REQ-023 RESP: pulse DONE[GRANT_ID] for exactly 1 cycle with OK[GRANT_ID]=result, drop BANK_REQ, update last_grant, and return to IDLE.
REQ-024 Latency: an uncontended approved request with BANK_ACK in the first WAIT cycle produces DONE 4 cycles after REQ rises.
REQ-025 Abort: if REQ[GRANT_ID] falls in ISSUE or WAIT (card removed), return to IDLE next cycle with no DONE pulse, BANK_REQ low, and no statistics update.
REQ-026 BANK_ACK while in IDLE, ISSUE or RESP is ignored.
REQ-027 BANK_ACK on the same cycle as the timeout wins: the bank result is used.
REQ-028 Requests arriving during a transaction wait; a requester is never skipped twice in succession while REQ is held.
REQ-029 DONE and OK are registered outputs, at most one bit set at a time.

Reset
REQ-030 RESET_N low asynchronously forces IDLE, last_grant=3, counter=0, and all outputs to 0, including mid-transaction; BANK_REQ drops immediately.
REQ-031 After RESET_N deasserts, the first arbitration grants the lowest-indexed active REQ.

Configuration
REQ-032 Macro BANK_ARB_STATS_EN defined: APPROVED_CNT increments on RESP with OK=1 and FAILED_CNT on RESP with OK=0; both saturate at 255 and are cleared by reset.
REQ-033 Macro BANK_ARB_STATS_EN undefined: counters are not built, and APPROVED_CNT and FAILED_CNT are tied to 0.

Structure
REQ-034 Shared package bank_arb_pkg holds the FSM state typedef, COST_W=3, CNT_W=8 and the NUM_REQ default.
REQ-035 One sub-module, rr_picker: combinational 4-way round-robin picker taking REQ and last_grant and returning valid plus index.

Verification
REQ-036 Set REQ=0001 with cost 3'd5, BANK_ACK=1 and BANK_OK=1 in the first WAIT cycle -> BANK_AMT=5, then DONE=0001 with OK=0001 four cycles after REQ.
REQ-037 Set REQ=1111 with all costs 3'd2 and the bank always approving -> grants occur in order 0,1,2,3,0 with one DONE per transaction.
REQ-038 Hold BANK_ACK low -> after 5 WAIT cycles, DONE pulses with OK=0 and FAILED_CNT=1 (macro on).
REQ-039 Set cost 3'd0 on machine 2 -> DONE=0100 with OK=0000 and BANK_REQ never high.
REQ-040 Drop REQ[1] during WAIT -> no DONE pulse, BANK_REQ low next cycle, and a later BANK_ACK is ignored.
REQ-041 Assert RESET_N low in WAIT -> BANK_REQ and BUSY go 0 immediately, then REQ=1010 grants machine 1 first.
